// File: rtl/pcm_frame_unpacker_if.sv
// Byte-FIFO read port plus the frame handshake toward the audio serializer.
// master = the unpacker side, slave = the FIFO/serializer side.
interface pcm_frame_unpacker_if;
  logic        fifo_empty;
  logic [7:0]  fifo_r_data;
  logic        fifo_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_left;
  logic [15:0] out_right;

  modport master (
    input  fifo_empty, fifo_r_data, out_ready,
    output fifo_rd, out_valid, out_left, out_right
  );

  modport slave (
    output fifo_empty, fifo_r_data, out_ready,
    input  fifo_rd, out_valid, out_left, out_right
  );
endinterface

// File: rtl/pcm_frame_unpacker.sv
// PCM frame unpacker: pops little-endian bytes from a fall-through FIFO,
// assembles 16-bit left/right frames (stereo or mono) and offers them over a
// valid/ready handshake. Counts FIFO starvation cycles with a saturating counter.
module pcm_frame_unpacker #(
  parameter int CNT_WIDTH  = 16,
  parameter bit OFFSET_BIN = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 mono,
  pcm_frame_unpacker_if.master bus,
  output logic [CNT_WIDTH-1:0] underrun_cnt
);

  typedef enum logic {COLLECT, HOLD} state_t;

  // Sign bit flip is folded into the high-byte capture so that the sample
  // registers (and hence the outputs) still read zero straight out of reset.
  localparam logic [7:0]           MSB_FLIP = {OFFSET_BIN, 7'b0};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_reg;
  logic [1:0]           idx_reg;
  logic                 mono_reg;
  logic [15:0]          left_reg;
  logic [15:0]          right_reg;
  logic                 valid_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;

  logic       rd;
  logic       starved;
  logic [7:0] hi_data;

  assign rd      = (state_reg == COLLECT) & en & ~bus.fifo_empty & ~flush & ~reset;
  assign starved = (state_reg == COLLECT) & en &  bus.fifo_empty & ~flush;
  assign hi_data = bus.fifo_r_data ^ MSB_FLIP;

  assign bus.fifo_rd   = rd;
  assign bus.out_valid = valid_reg;
  assign bus.out_left  = left_reg;
  assign bus.out_right = right_reg;
  assign underrun_cnt  = cnt_reg;

  // Byte collection / hold FSM with the starvation counter; reset beats flush beats the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= COLLECT;
      idx_reg   <= 2'd0;
      mono_reg  <= 1'b0;
      left_reg  <= 16'h0000;
      right_reg <= 16'h0000;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (flush) begin
      state_reg <= COLLECT;
      idx_reg   <= 2'd0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      if (starved && (cnt_reg != CNT_MAX))
        cnt_reg <= cnt_reg + CNT_ONE;
      case (state_reg)
        COLLECT: begin
          if (rd) begin
            case (idx_reg)
              2'd0: begin
                left_reg[7:0] <= bus.fifo_r_data;
                mono_reg      <= mono;   // frame mode fixed by the first byte
                idx_reg       <= 2'd1;
              end
              2'd1: begin
                left_reg[15:8] <= hi_data;
                if (mono_reg) begin
                  right_reg <= {hi_data, left_reg[7:0]};
                  state_reg <= HOLD;
                  valid_reg <= 1'b1;
                  idx_reg   <= 2'd0;
                end else begin
                  idx_reg <= 2'd2;
                end
              end
              2'd2: begin
                right_reg[7:0] <= bus.fifo_r_data;
                idx_reg        <= 2'd3;
              end
              default: begin
                right_reg[15:8] <= hi_data;
                state_reg       <= HOLD;
                valid_reg       <= 1'b1;
                idx_reg         <= 2'd0;
              end
            endcase
          end
        end
        HOLD: begin
          // Handshake completes regardless of en so a parked frame always drains.
          if (bus.out_ready) begin
            state_reg <= COLLECT;
            valid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
